// File: rtl/mem_access_unit_if.sv
// CPU request/response and data-RAM signals of mem_access_unit in one bundle.
// A request transfers on a rising edge where req_valid && req_ready; rsp_valid is a one-cycle completion pulse.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Turns byte/halfword/word CPU loads and stores into word RAM accesses,
// using read-modify-write for sub-word stores and lane extraction for sub-word loads.
module mem_access_unit #(
    parameter int RAM_LATENCY = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    mem_access_unit_if.slave       bus,
    output logic [1:0]             dbg_state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] LAST_WAIT = 2'(RAM_LATENCY);

    state_t      state_q;
    logic [1:0]  wait_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic        ram_we_q;
    logic [31:0] ram_addr_q;
    logic [31:0] ram_wdata_q;

    logic [31:0] rsp_rdata_d;
    logic [31:0] ram_wdata_d;
    logic        req_err;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (size)
            SZ_BYTE: extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    // Only the addressed lane changes; the rest of the word comes from the RAM read.
    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                          input logic [1:0] off, input logic [1:0] size);
        logic [31:0] m;
        m = w;
        if (size == SZ_BYTE) begin
            m[{off, 3'b000} +: 8] = wd[7:0];
        end else if (off[1]) begin
            m[31:16] = wd[15:0];
        end else begin
            m[15:0] = wd[15:0];
        end
        merge = m;
    endfunction

    assign req_err = (bus.req_size == 2'b11)
                   || (bus.req_size == SZ_HALF && bus.req_addr[0])
                   || (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00);

    assign rsp_rdata_d = extract(bus.ram_rdata, off_q, size_q, uns_q);
    assign ram_wdata_d = merge(bus.ram_rdata, wdata_q, off_q, size_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_q      <= 2'd0;
            off_q       <= 2'd0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 32'd0;
            ram_wdata_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        off_q       <= bus.req_addr[1:0];
                        size_q      <= bus.req_size;
                        uns_q       <= bus.req_unsigned;
                        write_q     <= bus.req_write;
                        wdata_q     <= bus.req_wdata;
                        ram_addr_q  <= {bus.req_addr[31:2], 2'b00};
                        req_ready_q <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        wait_q      <= 2'd0;
                        if (req_err) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (bus.req_write && bus.req_size == SZ_WORD) begin
                            ram_wdata_q <= bus.req_wdata;
                            ram_we_q    <= 1'b1;
                            state_q     <= WR;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                RD: begin
                    // The RAM word is valid in the final wait cycle only.
                    if (wait_q == LAST_WAIT) begin
                        if (write_q) begin
                            ram_wdata_q <= ram_wdata_d;
                            ram_we_q    <= 1'b1;
                            state_q     <= WR;
                        end else begin
                            rsp_rdata_q <= rsp_rdata_d;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
                WR: begin
                    ram_we_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: two instances (RAM latency 1 and 2), each with a word RAM model.
module tb_mem_access_unit;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_access_unit_if if0();
  mem_access_unit_if if1();
  logic [1:0] dbg0, dbg1;

  mem_access_unit #(.RAM_LATENCY(1)) u_dut0 (.clock(clock), .reset(reset), .bus(if0), .dbg_state_o(dbg0));
  mem_access_unit #(.RAM_LATENCY(2)) u_dut1 (.clock(clock), .reset(reset), .bus(if1), .dbg_state_o(dbg1));

  logic        sel, req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  assign if0.req_valid    = req_valid & ~sel;
  assign if1.req_valid    = req_valid & sel;
  assign if0.req_write    = req_write;
  assign if1.req_write    = req_write;
  assign if0.req_size     = req_size;
  assign if1.req_size     = req_size;
  assign if0.req_unsigned = req_unsigned;
  assign if1.req_unsigned = req_unsigned;
  assign if0.req_addr     = req_addr;
  assign if1.req_addr     = req_addr;
  assign if0.req_wdata    = req_wdata;
  assign if1.req_wdata    = req_wdata;

  logic        s_ready, s_rsp_valid, s_rsp_err;
  logic [31:0] s_rsp_rdata;
  assign s_ready     = sel ? if1.req_ready : if0.req_ready;
  assign s_rsp_valid = sel ? if1.rsp_valid : if0.rsp_valid;
  assign s_rsp_err   = sel ? if1.rsp_err   : if0.rsp_err;
  assign s_rsp_rdata = sel ? if1.rsp_rdata : if0.rsp_rdata;

  // RAM models: read data appears RAM_LATENCY cycles after the address.
  logic        poke_en, poke_sel;
  logic [5:0]  poke_idx;
  logic [31:0] poke_data;
  logic [31:0] mem0 [0:63];
  logic [31:0] mem1 [0:63];
  logic [31:0] rd0, rd1a, rd1b;
  logic [31:0] last_waddr0, last_wdata0;
  int wcnt0 = 0;
  int wcnt1 = 0;

  always @(posedge clock) begin
    if (poke_en && !poke_sel) mem0[poke_idx] <= poke_data;
    else if (if0.ram_we) begin
      mem0[if0.ram_addr[7:2]] <= if0.ram_wdata;
      last_waddr0 <= if0.ram_addr;
      last_wdata0 <= if0.ram_wdata;
      wcnt0 <= wcnt0 + 1;
    end
    rd0 <= mem0[if0.ram_addr[7:2]];
  end
  assign if0.ram_rdata = rd0;

  always @(posedge clock) begin
    if (poke_en && poke_sel) mem1[poke_idx] <= poke_data;
    else if (if1.ram_we) begin
      mem1[if1.ram_addr[7:2]] <= if1.ram_wdata;
      wcnt1 <= wcnt1 + 1;
    end
    rd1a <= mem1[if1.ram_addr[7:2]];
    rd1b <= rd1a;
  end
  assign if1.ram_rdata = rd1b;

  int n_checks = 0;
  int n_pass = 0;

  task automatic poke(input logic s, input logic [5:0] idx, input logic [31:0] d);
    @(negedge clock);
    poke_en = 1'b1; poke_sel = s; poke_idx = idx; poke_data = d;
    @(negedge clock);
    poke_en = 1'b0;
  endtask

  // Issues one request on the selected instance; lat counts cycles after acceptance until rsp_valid.
  task automatic issue(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output logic err, output logic [31:0] rd);
    int guard;
    @(negedge clock);
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d; req_valid = 1'b1;
    guard = 0;
    while (!s_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1;
    while (!s_rsp_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    err = s_rsp_err;
    rd = s_rsp_rdata;
  endtask

  task automatic test_reset();
    sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; poke_en = 1'b0; poke_sel = 1'b0; poke_idx = 6'd0; poke_data = 32'd0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++; if (if0.req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", if0.req_ready); else n_pass++;
    n_checks++; if (if0.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", if0.rsp_valid); else n_pass++;
    n_checks++; if (if0.ram_we !== 1'b0) $display("FAIL reset_ram_we: got %b expected 0", if0.ram_we); else n_pass++;
    n_checks++; if (if0.ram_addr !== 32'd0) $display("FAIL reset_ram_addr: got %h expected 0", if0.ram_addr); else n_pass++;
    n_checks++; if (if0.ram_wdata !== 32'd0) $display("FAIL reset_ram_wdata: got %h expected 0", if0.ram_wdata); else n_pass++;
    n_checks++; if (if0.rsp_rdata !== 32'd0) $display("FAIL reset_rsp_rdata: got %h expected 0", if0.rsp_rdata); else n_pass++;
    n_checks++; if (dbg0 !== 2'd0) $display("FAIL reset_state: got %0d expected 0", dbg0); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_word_store_load();
    int lat; logic err; logic [31:0] rd; int w0;
    w0 = wcnt0;
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, lat, err, rd);
    n_checks++; if (lat !== 2) $display("FAIL wstore_latency: got %0d expected 2", lat); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL wstore_err: got %b expected 0", err); else n_pass++;
    n_checks++; if (wcnt0 - w0 !== 1) $display("FAIL wstore_we_cycles: got %0d expected 1", wcnt0 - w0); else n_pass++;
    n_checks++; if (last_waddr0 !== 32'h10) $display("FAIL wstore_addr: got %h expected 00000010", last_waddr0); else n_pass++;
    n_checks++; if (mem0[4] !== 32'hDEADBEEF) $display("FAIL wstore_mem: got %h expected deadbeef", mem0[4]); else n_pass++;
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, err, rd);
    n_checks++; if (lat !== 3) $display("FAIL wload_latency: got %0d expected 3", lat); else n_pass++;
    n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL wload_data: got %h expected deadbeef", rd); else n_pass++;
    n_checks++; if (if0.ram_addr !== 32'h10) $display("FAIL ram_addr_held: got %h expected 00000010", if0.ram_addr); else n_pass++;
  endtask

  task automatic test_subword_store();
    int lat; logic err; logic [31:0] rd; int w0;
    poke(1'b0, 6'd8, 32'h11223344);
    w0 = wcnt0;
    issue(1'b1, 2'd0, 1'b0, 32'h22, 32'hFFFFFFAA, lat, err, rd);
    n_checks++; if (lat !== 4) $display("FAIL bstore_latency: got %0d expected 4", lat); else n_pass++;
    n_checks++; if (wcnt0 - w0 !== 1) $display("FAIL bstore_writes: got %0d expected 1", wcnt0 - w0); else n_pass++;
    n_checks++; if (last_wdata0 !== 32'h11AA3344) $display("FAIL bstore_wdata: got %h expected 11aa3344", last_wdata0); else n_pass++;
    n_checks++; if (last_waddr0 !== 32'h20) $display("FAIL bstore_addr: got %h expected 00000020", last_waddr0); else n_pass++;
    poke(1'b0, 6'd8, 32'h11223344);
    issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234BEEF, lat, err, rd);
    n_checks++; if (mem0[8] !== 32'hBEEF3344) $display("FAIL hstore_mem: got %h expected beef3344", mem0[8]); else n_pass++;
    n_checks++; if (rd !== 32'd0) $display("FAIL hstore_rdata: got %h expected 0", rd); else n_pass++;
    w0 = wcnt0;
    issue(1'b1, 2'd1, 1'b0, 32'h23, 32'h00005555, lat, err, rd);
    n_checks++; if (err !== 1'b1) $display("FAIL hstore_misaligned_err: got %b expected 1", err); else n_pass++;
    n_checks++; if (lat !== 1) $display("FAIL err_latency: got %0d expected 1", lat); else n_pass++;
    repeat (3) @(negedge clock);
    n_checks++; if (wcnt0 - w0 !== 0) $display("FAIL err_no_write: got %0d expected 0", wcnt0 - w0); else n_pass++;
    n_checks++; if (mem0[8] !== 32'hBEEF3344) $display("FAIL err_mem_kept: got %h expected beef3344", mem0[8]); else n_pass++;
  endtask

  task automatic test_loads();
    int lat; logic err; logic [31:0] rd;
    poke(1'b0, 6'd12, 32'h80FF7F01);
    issue(1'b0, 2'd0, 1'b0, 32'h32, 32'h0, lat, err, rd);
    n_checks++; if (rd !== 32'hFFFFFFFF) $display("FAIL lb_off2: got %h expected ffffffff", rd); else n_pass++;
    n_checks++; if (lat !== 3) $display("FAIL lb_latency: got %0d expected 3", lat); else n_pass++;
    issue(1'b0, 2'd0, 1'b1, 32'h32, 32'h0, lat, err, rd);
    n_checks++; if (rd !== 32'h000000FF) $display("FAIL lbu_off2: got %h expected 000000ff", rd); else n_pass++;
    issue(1'b0, 2'd0, 1'b0, 32'h33, 32'h0, lat, err, rd);
    n_checks++; if (rd !== 32'hFFFFFF80) $display("FAIL lb_off3: got %h expected ffffff80", rd); else n_pass++;
    issue(1'b0, 2'd0, 1'b0, 32'h30, 32'h0, lat, err, rd);
    n_checks++; if (rd !== 32'h00000001) $display("FAIL lb_off0: got %h expected 00000001", rd); else n_pass++;
    issue(1'b0, 2'd1, 1'b0, 32'h30, 32'h0, lat, err, rd);
    n_checks++; if (rd !== 32'h00007F01) $display("FAIL lh_off0: got %h expected 00007f01", rd); else n_pass++;
    issue(1'b0, 2'd1, 1'b0, 32'h32, 32'h0, lat, err, rd);
    n_checks++; if (rd !== 32'hFFFF80FF) $display("FAIL lh_off2: got %h expected ffff80ff", rd); else n_pass++;
    issue(1'b0, 2'd1, 1'b1, 32'h32, 32'h0, lat, err, rd);
    n_checks++; if (rd !== 32'h000080FF) $display("FAIL lhu_off2: got %h expected 000080ff", rd); else n_pass++;
  endtask

  task automatic test_illegal();
    int lat; logic err; logic [31:0] rd;
    issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, lat, err, rd);
    n_checks++; if (err !== 1'b1) $display("FAIL size11_err: got %b expected 1", err); else n_pass++;
    n_checks++; if (rd !== 32'd0) $display("FAIL size11_rdata: got %h expected 0", rd); else n_pass++;
    issue(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, lat, err, rd);
    n_checks++; if (err !== 1'b1) $display("FAIL word_misaligned_err: got %b expected 1", err); else n_pass++;
  endtask

  task automatic test_reset_mid_rmw();
    int lat; logic err; logic [31:0] rd; int w0;
    poke(1'b0, 6'd16, 32'h11223344);
    w0 = wcnt0;
    @(negedge clock);
    req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h41; req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    n_checks++; if (dbg0 !== 2'd1) $display("FAIL rmw_in_rd: got %0d expected 1", dbg0); else n_pass++;
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if (if0.req_ready !== 1'b1) $display("FAIL rmw_reset_ready: got %b expected 1", if0.req_ready); else n_pass++;
    n_checks++; if (if0.rsp_valid !== 1'b0) $display("FAIL rmw_reset_rsp: got %b expected 0", if0.rsp_valid); else n_pass++;
    n_checks++; if (if0.ram_we !== 1'b0) $display("FAIL rmw_reset_we: got %b expected 0", if0.ram_we); else n_pass++;
    reset = 1'b0;
    repeat (4) @(negedge clock);
    n_checks++; if (wcnt0 - w0 !== 0) $display("FAIL rmw_abandoned: got %0d writes expected 0", wcnt0 - w0); else n_pass++;
    n_checks++; if (mem0[16] !== 32'h11223344) $display("FAIL rmw_mem_kept: got %h expected 11223344", mem0[16]); else n_pass++;
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, lat, err, rd);
    n_checks++; if (rd !== 32'h11223344) $display("FAIL post_reset_load: got %h expected 11223344", rd); else n_pass++;
    n_checks++; if (lat !== 3) $display("FAIL post_reset_latency: got %0d expected 3", lat); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int first_rsp, second_rsp, ready_cyc;
    logic [31:0] rd_a, rd_b;
    first_rsp = 0; second_rsp = 0; ready_cyc = 0; rd_a = 32'd0; rd_b = 32'd0;
    @(negedge clock);
    req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (c == 1) req_addr = 32'h30;
      if (if0.rsp_valid) begin
        if (first_rsp == 0) begin first_rsp = c; rd_a = if0.rsp_rdata; end
        else if (second_rsp == 0) begin second_rsp = c; rd_b = if0.rsp_rdata; end
      end
      if (if0.req_ready && ready_cyc == 0) ready_cyc = c;
      if (ready_cyc != 0 && c == ready_cyc + 1) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    n_checks++; if (first_rsp !== 3) $display("FAIL b2b_first_rsp: got %0d expected 3", first_rsp); else n_pass++;
    n_checks++; if (rd_a !== 32'hDEADBEEF) $display("FAIL b2b_first_data: got %h expected deadbeef", rd_a); else n_pass++;
    n_checks++; if (ready_cyc !== 4) $display("FAIL b2b_ready_cycle: got %0d expected 4", ready_cyc); else n_pass++;
    n_checks++; if (second_rsp !== 7) $display("FAIL b2b_second_rsp: got %0d expected 7", second_rsp); else n_pass++;
    n_checks++; if (rd_b !== 32'h80FF7F01) $display("FAIL b2b_second_data: got %h expected 80ff7f01", rd_b); else n_pass++;
  endtask

  task automatic test_latency2();
    int lat; logic err; logic [31:0] rd; int w1;
    sel = 1'b1;
    poke(1'b1, 6'd4, 32'hCAFEF00D);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, err, rd);
    n_checks++; if (lat !== 4) $display("FAIL l2_load_latency: got %0d expected 4", lat); else n_pass++;
    n_checks++; if (rd !== 32'hCAFEF00D) $display("FAIL l2_load_data: got %h expected cafef00d", rd); else n_pass++;
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, lat, err, rd);
    n_checks++; if (rd !== 32'hFFFFFFCA) $display("FAIL l2_lb_off3: got %h expected ffffffca", rd); else n_pass++;
    w1 = wcnt1;
    issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h00000012, lat, err, rd);
    n_checks++; if (lat !== 5) $display("FAIL l2_bstore_latency: got %0d expected 5", lat); else n_pass++;
    n_checks++; if (wcnt1 - w1 !== 1) $display("FAIL l2_bstore_writes: got %0d expected 1", wcnt1 - w1); else n_pass++;
    n_checks++; if (mem1[4] !== 32'hCAFE120D) $display("FAIL l2_bstore_mem: got %h expected cafe120d", mem1[4]); else n_pass++;
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_subword_store();
    test_loads();
    test_illegal();
    test_reset_mid_rmw();
    test_back_to_back();
    test_latency2();
    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits directly upstream of the data-memory block (word-wide RAM, single write enable, byte address with word index taken from address bits [15:2]).
- Converts CPU load/store requests of byte, halfword or word size into word RAM accesses.
- Sub-word stores are done as read-modify-write because the RAM has no byte enables. Sub-word loads are extracted and sign- or zero-extended.
- Stalls the CPU through a valid/ready handshake and reports misaligned accesses.

Parameters:
- RAM_LATENCY, 1, cycles from `ram_addr` presented to `ram_rdata` valid (legal values 1..3).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  CPU request present.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  one-cycle pulse: transaction complete.
- rsp_err  output  1  valid with `rsp_valid`: misaligned or illegal size.
- rsp_rdata  output  32  load result, valid with `rsp_valid`; 0 for stores and errors.
- ram_we  output  1  data-memory write enable.
- ram_addr  output  32  data-memory byte address, always word-aligned ({addr[31:2],2'b00}).
- ram_wdata  output  32  data-memory write word.
- ram_rdata  input  32  data-memory read word.

Behaviour:
- Byte lanes are little-endian: offset 0 is [7:0], offset 3 is [31:24]. Halfword offset 0 is [15:0], offset 2 is [31:16].
- FSM states: IDLE, RD, WR, RESP.
- Acceptance: a request is accepted on a rising edge with `req_valid` && `req_ready`. Then:
  - addr/size/unsigned/wdata are latched.
  - `ram_addr` is registered from the aligned `req_addr`.
- Error check, done at acceptance: size=11, half with addr[0]=1, or word with addr[1:0]!=0 is an error.
  - Error path is IDLE -> RESP with `rsp_err`=1 and `rsp_rdata`=0.
  - No RAM write is ever issued for an error.
- Load: IDLE -> RD -> RESP.
  - RD lasts RAM_LATENCY+1 cycles, using an internal wait counter.
  - `ram_rdata` is sampled in the last RD cycle.
  - The selected lane is extended per `req_unsigned` and registered into `rsp_rdata`.
- Word store: IDLE -> WR -> RESP.
  - `ram_wdata` = `req_wdata`, registered at acceptance.
- Sub-word store: IDLE -> RD -> WR -> RESP.
  - In the last RD cycle, `ram_wdata` = `ram_rdata` with the addressed lane replaced by `req_wdata`[7:0] or [15:0]. All other lanes are preserved.
- `ram_we` = (state==WR), exactly one cycle per store. `ram_addr` and `ram_wdata` are stable throughout WR.
- RESP lasts one cycle: `rsp_valid`=1, then IDLE. `req_ready`=0 in RD, WR and RESP. A request presented during RESP waits for IDLE.
- Latency, cycles after the acceptance edge until `rsp_valid` (L = RAM_LATENCY):
  - load: 2+L
  - word store: 2
  - sub-word store: 3+L
  - error: 1
- `ram_addr` is held unchanged from acceptance until the next acceptance.
- Reset (any state, including mid read-modify-write) gives, on the next edge:
  - state=IDLE
  - `ram_we`=0, so the pending write is abandoned and RAM is not modified
  - `ram_addr`=0, `ram_wdata`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `req_ready`=1
  - wait counter=0
- Input changes while busy are ignored; only latched values are used.

Test Plan:
- Word store then word load, L=1:
  - Store 0xDEADBEEF to 0x10: `ram_we` pulses 1 cycle, `ram_addr`=0x10, `rsp_valid` 2 cycles after acceptance.
  - Load 0x10: `rsp_rdata`=0xDEADBEEF, `rsp_valid` 3 cycles after acceptance.
- Byte store, RAM word 0x11223344 at 0x20: store byte 0xAA to 0x22.
  - Exactly one write, `ram_wdata`=0x11AA3344.
  - `rsp_valid` 4 cycles after acceptance.
- Halfword store 0xBEEF to 0x22 on word 0x11223344:
  - Written 0xBEEF3344.
  - Halfword store to 0x23: `rsp_err`=1, `ram_we` never asserted, word unchanged.
- Loads on word 0x80FF7F01:
  - Byte at offset 2, signed: 0xFFFFFFFF.
  - Byte at offset 2, unsigned: 0x000000FF.
  - Byte at offset 3, signed: 0xFFFFFF80.
  - Half at offset 0, signed: 0x00007F01.
- Reset during the RD cycle of a byte store:
  - `ram_we` stays 0, RAM word unchanged.
  - Next edge: `req_ready`=1, `rsp_valid`=0.
  - A following word load completes normally.
- Back-to-back requests with `req_valid` held high:
  - The second is accepted only in the cycle after RESP.
  - Word load with `req_size`=11: `rsp_err`=1, `rsp_rdata`=0.
  - Repeat the load test with RAM_LATENCY=2: load latency is 4.
